serial_pair_serializer_msb_first_using_fsm: RTL and testbench
=============================================================

Name: serial_pair_serializer_msb_first_using_fsm

Overview:
Transmit-side companion to the serial comparators. Accepts a pair of parallel WIDTH-bit words (a, b) over a valid/ready handshake and shifts both out in lockstep, one bit per clock, most significant bit first. It also generates framing strobes and a comparator clear pulse, so a downstream serial comparator sees one clean word per frame and is cleared between frames without losing a bit.

Parameters:
WIDTH, 8, bits per word; legal range 1..32.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  parallel word pair offered
in_ready  output  1  block accepts the pair this cycle
in_a  input  WIDTH  word a
in_b  input  WIDTH  word b
serial_a  output  1  current bit of a
serial_b  output  1  current bit of b
serial_valid  output  1  serial_a/serial_b carry a live bit
serial_first  output  1  current bit is the first bit of a frame (MSB)
serial_last  output  1  current bit is the last bit of a frame (LSB)
cmp_rst  output  1  clear strobe for the downstream comparator's rst

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- All outputs except in_ready are registered. in_ready is combinational from state and bit counter only, never from in_valid.
- Reset values: serial_a=0, serial_b=0, serial_valid=0, serial_first=0, serial_last=0, cmp_rst=0, FSM=ST_IDLE, bit counter=0. in_ready=1 in the first cycle after reset.
- FSM states:
  ST_IDLE: no frame in progress. in_ready=1.
  ST_SHIFT: a frame is being sent. in_ready=1 only during the last-bit cycle.
- Handshake: transfer occurs on a rising edge with in_valid & in_ready. in_a/in_b load into two WIDTH-bit shift registers. The counter loads WIDTH-1. FSM goes to ST_SHIFT.
- Latency: the MSB appears on serial_a/serial_b in the cycle after the accepting edge, with serial_valid=1 and serial_first=1.
- Each ST_SHIFT cycle presents the shift-register MSBs. At the edge, both registers shift left by 1 and the counter decrements.
- Last bit: the cycle where the counter is 0. serial_last=1 and cmp_rst=1 in the same cycle. The comparator result is valid combinationally during that cycle, and its state clears at the closing edge.
- After the last bit:
  - with no new transfer: FSM returns to ST_IDLE. serial_* outputs become 0 and serial_valid=0. Idle zeros keep a comparator in its equal state.
  - with a transfer in the last-bit cycle (back-to-back): the next MSB follows with no gap. Sustained throughput is one word pair per WIDTH cycles.
- Counter width is max(1, $clog2(WIDTH)) bits.
- WIDTH=1: serial_first, serial_last and cmp_rst are all 1 in the single bit cycle. in_ready stays 1 continuously.
- In_valid while in_ready=0 is ignored. The source must hold the data. Nothing is lost or duplicated.
- rst asserted mid-frame aborts the frame immediately. The next cycle shows all reset values. No partial frame resumes.

Optional Feature:
SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN
- Defined: bits go out least significant first. The shift registers shift right and serial_* take bit 0. serial_first marks the LSB and serial_last marks the MSB. Used to feed the LSB-first comparator.
- Undefined: MSB-first behaviour as specified above.
- Handshake, latency, strobes and cmp_rst timing are identical in both builds.

Test Plan:
- Reset release, in_valid=0 for 10 cycles -> in_ready=1; serial_valid, serial_a, serial_b, cmp_rst all 0 throughout.
- WIDTH=8, single pair a=8'hA5, b=8'h5A -> serial_a over 8 cycles = 1,0,1,0,0,1,0,1 and serial_b = 0,1,0,1,1,0,1,0. serial_first on cycle 1, serial_last and cmp_rst on cycle 8. A connected MSB-first comparator shows a_greater_b=1 at cycle 8.
- Back-to-back pairs (8'h3C,8'h3C) then (8'h10,8'h11), in_valid held high -> 16 contiguous serial_valid cycles. in_ready=1 only in cycles 8 and 16. The comparator shows a_eq_b=1 at cycle 8 and a_less_b=1 at cycle 16.
- in_valid pulsed while mid-frame (in_ready=0) -> no transfer occurs. The pair is accepted only when re-presented during the last-bit cycle or in ST_IDLE.
- rst asserted at bit 4 of a frame -> next cycle all outputs at reset values and in_ready=1. A new pair 8'hFF/8'h00 then serializes from its MSB.
- WIDTH=1 build with pairs (1,0),(0,1) back-to-back -> every cycle has serial_first=serial_last=cmp_rst=1. serial_a=1,0 and serial_b=0,1.

Source files
------------

// File: rtl/serial_pair_serializer_msb_first_using_fsm.sv
// serial_pair_serializer_msb_first_using_fsm
//   Purpose     : loads a parallel word pair (a, b) and shifts both out in
//                 lockstep, one bit per clock, MSB first, with frame strobes
//                 and a clear pulse for a downstream serial comparator.
//   Latency     : first bit is presented the cycle after the accepting edge;
//                 one pair per WIDTH cycles sustained, no gap back-to-back.
//   Backpressure: in_ready is high in ST_IDLE and in the last-bit cycle only;
//                 in_valid while in_ready is low is ignored (source holds data).
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   in_valid/in_ready         pair handshake, in_ready depends on state/counter only
//   in_a, in_b                WIDTH-bit parallel words
//   serial_a, serial_b        current bit of each word (0 when idle)
//   serial_valid              a live bit is on serial_a/serial_b
//   serial_first/serial_last  first / last bit of the frame
//   cmp_rst                   comparator clear, coincident with serial_last
// Build option:
//   SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN  shift out LSB first (first marks the
//   LSB, last marks the MSB); timing of handshake and strobes is unchanged.
module serial_pair_serializer_msb_first_using_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             serial_a,
  output logic             serial_b,
  output logic             serial_valid,
  output logic             serial_first,
  output logic             serial_last,
  output logic             cmp_rst
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN
  localparam int OUT_BIT = 0;
`else
  localparam int OUT_BIT = WIDTH - 1;
`endif

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] w_sh_a_nxt;
  logic [WIDTH-1:0] w_sh_b_nxt;
  logic             w_load;

  logic r_serial_a;
  logic r_serial_b;
  logic r_serial_valid;
  logic r_serial_first;
  logic r_serial_last;
  logic r_cmp_rst;
  logic w_serial_a_nxt;
  logic w_serial_b_nxt;
  logic w_serial_valid_nxt;
  logic w_serial_first_nxt;
  logic w_serial_last_nxt;
  logic w_cmp_rst_nxt;

  // Ready during the last-bit cycle lets a new pair follow with no gap.
  // The counter rests at 0 in ST_IDLE, so with WIDTH=1 ready never drops.
  assign in_ready = (r_state == ST_IDLE) || (r_cnt == '0);
  assign w_load   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sh_a  <= '0;
      r_sh_b  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sh_a  <= w_sh_a_nxt;
      r_sh_b  <= w_sh_b_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_a_nxt  = r_sh_a;
    w_sh_b_nxt  = r_sh_b;

    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = CW'(WIDTH - 1);
          w_sh_a_nxt  = in_a;
          w_sh_b_nxt  = in_b;
        end
      end
      ST_SHIFT: begin
        if (w_load) begin
          // Only possible in the last-bit cycle: reload instead of going idle.
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = CW'(WIDTH - 1);
          w_sh_a_nxt  = in_a;
          w_sh_b_nxt  = in_b;
        end else begin
`ifdef SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN
          w_sh_a_nxt = r_sh_a >> 1;
          w_sh_b_nxt = r_sh_b >> 1;
`else
          w_sh_a_nxt = r_sh_a << 1;
          w_sh_b_nxt = r_sh_b << 1;
`endif
          if (r_cnt == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Output registers are fed from the next state so every strobe lines up
    // with the bit it describes. Idle forces zeros so a comparator stays equal.
    w_serial_valid_nxt = (w_state_nxt == ST_SHIFT);
    w_serial_a_nxt     = w_serial_valid_nxt & w_sh_a_nxt[OUT_BIT];
    w_serial_b_nxt     = w_serial_valid_nxt & w_sh_b_nxt[OUT_BIT];
    w_serial_first_nxt = w_load;
    w_serial_last_nxt  = w_serial_valid_nxt && (w_cnt_nxt == '0);
    w_cmp_rst_nxt      = w_serial_last_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_serial_a     <= 1'b0;
      r_serial_b     <= 1'b0;
      r_serial_valid <= 1'b0;
      r_serial_first <= 1'b0;
      r_serial_last  <= 1'b0;
      r_cmp_rst      <= 1'b0;
    end else begin
      r_serial_a     <= w_serial_a_nxt;
      r_serial_b     <= w_serial_b_nxt;
      r_serial_valid <= w_serial_valid_nxt;
      r_serial_first <= w_serial_first_nxt;
      r_serial_last  <= w_serial_last_nxt;
      r_cmp_rst      <= w_cmp_rst_nxt;
    end
  end

  assign serial_a     = r_serial_a;
  assign serial_b     = r_serial_b;
  assign serial_valid = r_serial_valid;
  assign serial_first = r_serial_first;
  assign serial_last  = r_serial_last;
  assign cmp_rst      = r_cmp_rst;

endmodule

// File: tb/tb_serial_pair_serializer_msb_first_using_fsm.sv
// tb_serial_pair_serializer_msb_first_using_fsm
//   Purpose : directed stimulus with a scoreboard of expected serial bits and
//             expected comparator verdicts, checked by an independent monitor.
//   Also drives a WIDTH=1 instance for the single-bit frame case.
module tb_serial_pair_serializer_msb_first_using_fsm;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         serial_a, serial_b, serial_valid, serial_first, serial_last, cmp_rst;

  logic       in_valid1;
  logic       in_ready1;
  logic [0:0] in_a1;
  logic [0:0] in_b1;
  logic       serial_a1, serial_b1, serial_valid1, serial_first1, serial_last1, cmp_rst1;

  always #5 clk = ~clk;

  serial_pair_serializer_msb_first_using_fsm #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .serial_a(serial_a), .serial_b(serial_b), .serial_valid(serial_valid),
    .serial_first(serial_first), .serial_last(serial_last), .cmp_rst(cmp_rst)
  );

  serial_pair_serializer_msb_first_using_fsm #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .serial_a(serial_a1), .serial_b(serial_b1), .serial_valid(serial_valid1),
    .serial_first(serial_first1), .serial_last(serial_last1), .cmp_rst(cmp_rst1)
  );

  typedef struct packed {
    logic a;
    logic b;
    logic first;
    logic last;
  } bit_t;

  bit_t exp_q[$];
  int   frame_q[$];   // 0 = equal, 1 = a greater, 2 = a less

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected bit stream of one frame, in transmission order.
  task automatic push_frame(input logic [W-1:0] a, input logic [W-1:0] b, input int res);
    logic [W-1:0] va;
    logic [W-1:0] vb;
    int idx;
    va = a;
    vb = b;
    for (int k = 0; k < W; k++) begin
`ifdef SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN
      idx = k;
`else
      idx = W - 1 - k;
`endif
      exp_q.push_back('{a: va[idx], b: vb[idx], first: (k == 0), last: (k == W - 1)});
    end
    frame_q.push_back(res);
  endtask

  // Offers a pair, waits (bounded) for acceptance, returns #1 after the
  // accepting edge with in_valid still high. waits = non-ready cycles seen.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input int res,
                      output int waits);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    waits    = 0;
    while (!in_ready && waits < 100) begin
      @(posedge clk);
      #1;
      waits++;
    end
    check("accept_timeout", (waits >= 100), 0);
    @(posedge clk);
    push_frame(a, b, res);
    #1;
  endtask

  // Monitor: scoreboard pop plus a reference serial comparator that is
  // cleared by cmp_rst at the closing edge of the last bit.
  logic gt = 1'b0;
  logic lt = 1'b0;
  logic prev_live = 1'b0;

  always @(negedge clk) begin
    bit_t e;
    int   res;
    logic ngt, nlt;
    if (rst) begin
      gt        = 1'b0;
      lt        = 1'b0;
      prev_live = 1'b0;
    end else if (serial_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bit", {31'd0, serial_valid}, 0);
      end else begin
        e = exp_q.pop_front();
        check("serial_a", serial_a, e.a);
        check("serial_b", serial_b, e.b);
        check("serial_first", serial_first, e.first);
        check("serial_last", serial_last, e.last);
        check("cmp_rst", cmp_rst, e.last);
      end
`ifdef SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN
      ngt = (serial_a != serial_b) ? serial_a : gt;
      nlt = (serial_a != serial_b) ? serial_b : lt;
`else
      ngt = (gt | lt) ? gt : (serial_a & ~serial_b);
      nlt = (gt | lt) ? lt : (~serial_a & serial_b);
`endif
      if (serial_last) begin
        res = ngt ? 1 : (nlt ? 2 : 0);
        if (frame_q.size() == 0) check("unexpected_frame_end", 1, 0);
        else check("cmp_result", res, frame_q.pop_front());
      end
      if (cmp_rst) begin
        ngt = 1'b0;
        nlt = 1'b0;
      end
      gt        = ngt;
      lt        = nlt;
      prev_live = ~serial_last;
    end else begin
      if (prev_live) check("frame_gap", serial_valid, 1);
      check("idle_outputs", {serial_a, serial_b, serial_first, serial_last, cmp_rst}, 0);
      prev_live = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_valid1 = 1'b0;
    in_a1     = '0;
    in_b1     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {serial_a, serial_b, serial_valid, serial_first, serial_last, cmp_rst}, 0);
    check("reset_in_ready", in_ready, 1);
    rst = 1'b0;

    // Idle after reset: ready stays high, monitor checks zero outputs.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("idle_in_ready", in_ready, 1);
    end

    // Single pair A5/5A: ready low through the frame, high in the last bit.
    send(8'hA5, 8'h5A, 1, w);
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check("frame_in_ready", in_ready, (c == 8));
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back: second pair accepted in the last-bit cycle of the first.
    send(8'h3C, 8'h3C, 0, w);
    check("idle_accept_wait", w, 0);
    send(8'h10, 8'h11, 2, w);
    check("b2b_accept_wait", w, 7);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // in_valid pulsed mid-frame is ignored; re-presented later it is taken.
    send(8'h81, 8'h18, 1, w);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = 8'hC3;
    in_b     = 8'h3C;
    check("midframe_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("ignored_pulse_queue", exp_q.size(), 0);
    send(8'hC3, 8'h3C, 1, w);
    check("represent_wait", w, 0);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Reset at bit 4 aborts the frame.
    send(8'h96, 8'h69, 1, w);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bit4_valid", serial_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    frame_q.delete();
    check("abort_outputs", {serial_a, serial_b, serial_valid, serial_first, serial_last, cmp_rst}, 0);
    check("abort_in_ready", in_ready, 1);
    rst = 1'b0;
    send(8'hFF, 8'h00, 1, w);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // WIDTH=1: every cycle is first, last and clear; ready never drops.
    in_valid1 = 1'b1;
    in_a1     = 1'b1;
    in_b1     = 1'b0;
    check("w1_ready0", in_ready1, 1);
    @(posedge clk);
    #1;
    check("w1_bit0", {serial_valid1, serial_a1, serial_b1, serial_first1, serial_last1, cmp_rst1}, 6'b110111);
    check("w1_ready1", in_ready1, 1);
    in_a1 = 1'b0;
    in_b1 = 1'b1;
    @(posedge clk);
    #1;
    check("w1_bit1", {serial_valid1, serial_a1, serial_b1, serial_first1, serial_last1, cmp_rst1}, 6'b101111);
    check("w1_ready2", in_ready1, 1);
    in_valid1 = 1'b0;
    @(posedge clk);
    #1;
    check("w1_idle", {serial_valid1, serial_a1, serial_b1, serial_first1, serial_last1, cmp_rst1}, 0);
    check("w1_ready3", in_ready1, 1);

    check("bits_outstanding", exp_q.size(), 0);
    check("frames_outstanding", frame_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
